// File: rtl/rot_regfile_write_sched.sv
// rot_regfile_write_sched: round-robin write-port scheduler with bulk-clear sequencer for the 16x4 rotating register file
//   req/req_addr/req_data : per-requester level request with packed address/data
//   ack                   : one-cycle pulse coincident with that requester's write
//   clear_start/value     : begin a bulk clear writing clear_value to every address
//   clear_busy/done       : clear in progress / pulse on the final clear write
//   rf_w_addr/data_in/set : register-file write port
//   grant_id              : index of the last granted requester
module rot_regfile_write_sched #(
    parameter int NUM_REQ   = 2,
    parameter int ADDR_BITS = 4,
    parameter int NUM_REGS  = 16,
    parameter int DATA_BITS = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*ADDR_BITS-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
    output logic [NUM_REQ-1:0]             ack,
    input  logic                           clear_start,
    input  logic [DATA_BITS-1:0]           clear_value,
    output logic                           clear_busy,
    output logic                           clear_done,
    output logic [ADDR_BITS-1:0]           rf_w_addr,
    output logic [DATA_BITS-1:0]           rf_data_in,
    output logic                           rf_set_data,
    output logic [1:0]                     grant_id
);
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t state, state_n;
    logic [NUM_REQ-1:0]   elig, ack_n;
    logic [1:0]           idx, pick, gid_n;
    logic                 found, set_n, busy_n, done_n;
    logic [ADDR_BITS-1:0] addr_n, nxt;
    logic [DATA_BITS-1:0] data_n;
    // A requester acked this cycle is still holding req for the write just made.
    assign elig = req & ~ack;
    assign nxt  = rf_w_addr + ADDR_BITS'(1);
    // Descending scan so the smallest offset after grant_id wins.
    always_comb begin
        idx   = '0;
        pick  = grant_id;
        found = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = 2'((int'(grant_id) + k) % NUM_REQ);
            if ((elig & (NUM_REQ'(1) << idx)) != '0) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end
    // rf_data_in itself holds the latched clear value for the whole sequence.
    always_comb begin
        state_n = state;
        ack_n   = '0;
        set_n   = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        addr_n  = rf_w_addr;
        data_n  = rf_data_in;
        gid_n   = grant_id;
        if (state == CLEAR) begin
            if (clear_done) begin
                state_n = IDLE;
            end else begin
                set_n  = 1'b1;
                busy_n = 1'b1;
                addr_n = nxt;
                done_n = nxt == ADDR_BITS'(NUM_REGS - 1);
            end
        end else if (clear_start) begin
            state_n = CLEAR;
            set_n   = 1'b1;
            busy_n  = 1'b1;
            addr_n  = '0;
            data_n  = clear_value;
            done_n  = NUM_REGS == 1;
        end else if (found) begin
            set_n  = 1'b1;
            ack_n  = NUM_REQ'(1) << pick;
            gid_n  = pick;
            addr_n = ADDR_BITS'(req_addr >> (int'(pick) * ADDR_BITS));
            data_n = DATA_BITS'(req_data >> (int'(pick) * DATA_BITS));
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ack         <= '0;
            rf_set_data <= 1'b0;
            clear_busy  <= 1'b0;
            clear_done  <= 1'b0;
            rf_w_addr   <= '0;
            rf_data_in  <= '0;
            grant_id    <= 2'(NUM_REQ - 1);
        end else begin
            state       <= state_n;
            ack         <= ack_n;
            rf_set_data <= set_n;
            clear_busy  <= busy_n;
            clear_done  <= done_n;
            rf_w_addr   <= addr_n;
            rf_data_in  <= data_n;
            grant_id    <= gid_n;
        end
    end
endmodule

// File: tb/tb_rot_regfile_write_sched.sv
// tb_rot_regfile_write_sched: directed self-checking bench for rot_regfile_write_sched
module tb_rot_regfile_write_sched;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req = '0;
    logic [7:0] req_addr = '0;
    logic [7:0] req_data = '0;
    logic [1:0] ack;
    logic       clear_start = 1'b0;
    logic [3:0] clear_value = '0;
    logic       clear_busy, clear_done, rf_set_data;
    logic [3:0] rf_w_addr, rf_data_in;
    logic [1:0] grant_id;
    logic [3:0] mem [16];
    int checks = 0;
    int errors = 0;

    rot_regfile_write_sched dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
        .ack(ack), .clear_start(clear_start), .clear_value(clear_value),
        .clear_busy(clear_busy), .clear_done(clear_done), .rf_w_addr(rf_w_addr),
        .rf_data_in(rf_data_in), .rf_set_data(rf_set_data), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rf_set_data) mem[rf_w_addr] <= rf_data_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("rst_ack", 32'(ack), 0);
        chk("rst_set", 32'(rf_set_data), 0);
        chk("rst_busy", 32'(clear_busy), 0);
        chk("rst_done", 32'(clear_done), 0);
        chk("rst_addr", 32'(rf_w_addr), 0);
        chk("rst_data", 32'(rf_data_in), 0);
        chk("rst_gid", 32'(grant_id), 1);

        req = 2'b01; req_addr = 8'h05; req_data = 8'h0A;
        step();
        req = '0;
        chk("single_set", 32'(rf_set_data), 1);
        chk("single_addr", 32'(rf_w_addr), 5);
        chk("single_data", 32'(rf_data_in), 4'hA);
        chk("single_ack", 32'(ack), 2'b01);
        chk("single_gid", 32'(grant_id), 0);
        step();
        chk("single_idle_set", 32'(rf_set_data), 0);
        chk("single_hold_addr", 32'(rf_w_addr), 5);
        chk("single_mem5", 32'(mem[5]), 4'hA);

        do_reset();
        req = 2'b11; req_addr = 8'h21; req_data = 8'h73;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rr_ack", 32'(ack), (i % 2 == 0) ? 2'b01 : 2'b10);
            chk("rr_gid", 32'(grant_id), i % 2);
            chk("rr_set", 32'(rf_set_data), 1);
            chk("rr_addr", 32'(rf_w_addr), (i % 2 == 0) ? 1 : 2);
            chk("rr_data", 32'(rf_data_in), (i % 2 == 0) ? 3 : 7);
        end
        req = '0;
        step();
        chk("rr_drop_ack", 32'(ack), 0);

        req = 2'b10; req_addr = 8'h60; req_data = 8'h90;
        for (int i = 1; i <= 6; i++) begin
            step();
            chk("hold_ack", 32'(ack), (i % 2 == 1) ? 2'b10 : 2'b00);
            chk("hold_set", 32'(rf_set_data), i % 2);
        end
        req = '0;
        step();

        clear_start = 1'b1; clear_value = 4'h0;
        step();
        clear_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("clr_set", 32'(rf_set_data), 1);
            chk("clr_addr", 32'(rf_w_addr), i);
            chk("clr_data", 32'(rf_data_in), 0);
            chk("clr_busy", 32'(clear_busy), 1);
            chk("clr_done", 32'(clear_done), i == 15);
            clear_start = (i == 7);
            clear_value = 4'h9;
            step();
        end
        clear_start = 1'b0;
        chk("clr_end_busy", 32'(clear_busy), 0);
        chk("clr_end_set", 32'(rf_set_data), 0);
        chk("clr_end_done", 32'(clear_done), 0);
        for (int i = 0; i < 16; i++) chk("clr_mem", 32'(mem[i]), 0);

        req = 2'b01; req_addr = 8'h09; req_data = 8'h0F;
        clear_start = 1'b1; clear_value = 4'h3;
        step();
        clear_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("col_addr", 32'(rf_w_addr), i);
            chk("col_data", 32'(rf_data_in), 3);
            chk("col_ack", 32'(ack), 0);
            step();
        end
        chk("col_exit_busy", 32'(clear_busy), 0);
        chk("col_exit_ack", 32'(ack), 0);
        chk("col_exit_set", 32'(rf_set_data), 0);
        step();
        req = '0;
        chk("col_ack", 32'(ack), 2'b01);
        chk("col_set", 32'(rf_set_data), 1);
        chk("col_waddr", 32'(rf_w_addr), 9);
        chk("col_wdata", 32'(rf_data_in), 4'hF);
        step();
        for (int i = 0; i < 16; i++) chk("col_mem", 32'(mem[i]), (i == 9) ? 4'hF : 4'h3);

        clear_start = 1'b1; clear_value = 4'hC;
        step();
        clear_start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("rmc_5th_addr", 32'(rf_w_addr), 4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rmc_set", 32'(rf_set_data), 0);
        chk("rmc_busy", 32'(clear_busy), 0);
        chk("rmc_done", 32'(clear_done), 0);
        chk("rmc_addr", 32'(rf_w_addr), 0);
        chk("rmc_gid", 32'(grant_id), 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rmc_quiet", 32'(rf_set_data), 0);
        end
        for (int i = 0; i < 16; i++)
            chk("rmc_mem", 32'(mem[i]), (i < 5) ? 4'hC : (i == 9) ? 4'hF : 4'h3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
